// File: rtl/wcseq.sv
// wcseq: block-transfer sequencer that steers an external 8-bit up/down word counter.
// Moore machine: every output decodes from the registered state, data and dir only.
module wcseq #(
    parameter bit AUTOINIT = 1'b0
) (
    input  logic       clk,
    input  logic       resseq,
    input  logic       start,
    input  logic [7:0] count,
    input  logic       dir,
    input  logic       abort,
    input  logic       dreq,
    output logic       dack,
    output logic [7:0] data,
    output logic       plwc,
    output logic       enw,
    output logic       incw,
    output logic       decw,
    output logic       wci,
    input  logic       wco,
    output logic       busy,
    output logic       tc,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_data;
    logic [7:0] r_base;
    logic       r_dir;
    logic       w_accept;
    logic       w_reload;

    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_reload = (r_state == S_DONE) && AUTOINIT && !abort;

    always_ff @(posedge clk) begin
        if (resseq) begin
            r_state <= S_IDLE;
            r_data  <= 8'h00;
            r_base  <= 8'h00;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_base <= count;
                r_data <= count;
                r_dir  <= dir;
            end else if (w_reload) begin
                r_data <= r_base;
            end
        end
    end

    // abort overrides every transition; wco only matters while a word is in flight
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = S_LOAD;
                S_LOAD: w_next = S_WAIT;
                S_WAIT: if (dreq) w_next = S_XFER;
                S_XFER: w_next = wco ? S_WAIT : S_DONE;
                S_DONE: w_next = AUTOINIT ? S_LOAD : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign plwc        = (r_state == S_LOAD);
    assign dack        = (r_state == S_XFER);
    assign enw         = (r_state == S_XFER);
    assign incw        = (r_state == S_XFER) && r_dir;
    assign decw        = (r_state == S_XFER) && !r_dir;
    assign tc          = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign wci         = 1'b0;
    assign data        = r_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wcseq.sv
// Bench for wcseq: two instances (AUTOINIT 0 and 1), each with a word-counter model.
// A block-level model checks outputs every cycle; directed tasks pin exact cycle timing.
module tb_wcseq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] AUTO = 2'b10;

  logic [1:0] resseq, start, dir, abort, dreq, wco;
  logic [7:0] count [2];
  logic [1:0] dack, plwc, enw, incw, decw, wci, busy, tc;
  logic [7:0] data [2];
  logic [2:0] dbg [2];
  logic [7:0] wc [2] = '{8'h00, 8'h00};

  int n_chk = 0;
  int n_fail = 0;

  wcseq #(.AUTOINIT(1'b0)) dut0 (
    .clk(clk), .resseq(resseq[0]), .start(start[0]), .count(count[0]), .dir(dir[0]),
    .abort(abort[0]), .dreq(dreq[0]), .dack(dack[0]), .data(data[0]), .plwc(plwc[0]),
    .enw(enw[0]), .incw(incw[0]), .decw(decw[0]), .wci(wci[0]), .wco(wco[0]),
    .busy(busy[0]), .tc(tc[0]), .o_dbg_state(dbg[0])
  );

  wcseq #(.AUTOINIT(1'b1)) dut1 (
    .clk(clk), .resseq(resseq[1]), .start(start[1]), .count(count[1]), .dir(dir[1]),
    .abort(abort[1]), .dreq(dreq[1]), .dack(dack[1]), .data(data[1]), .plwc(plwc[1]),
    .enw(enw[1]), .incw(incw[1]), .decw(decw[1]), .wci(wci[1]), .wco(wco[1]),
    .busy(busy[1]), .tc(tc[1]), .o_dbg_state(dbg[1])
  );

  // external word counter: load on plwc, step on enw; wco low when the step wraps
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (plwc[i] === 1'b1) wc[i] <= data[i];
      else if (enw[i] === 1'b1) wc[i] <= (incw[i] === 1'b1) ? wc[i] + 8'd1 : wc[i] - 8'd1;
    end
  end
  assign wco[0] = ~(enw[0] & ((incw[0] & (wc[0] == 8'hFF)) | (decw[0] & (wc[0] == 8'h00))));
  assign wco[1] = ~(enw[1] & ((incw[1] & (wc[1] == 8'hFF)) | (decw[1] & (wc[1] == 8'h00))));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // block-level model: busy span, load strobe, word count per block, terminal pulse
  bit         m_valid [2] = '{1'b0, 1'b0};
  logic       m_busy [2], m_plwc [2], m_tc [2], m_dir [2];
  logic       p_dack [2], p_dreq [2], p_plwc [2], p_tc [2], p_busy [2];
  logic [7:0] m_data [2], m_base [2];
  int         m_words [2], m_dcnt [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic n_tc, n_plwc;
      if (m_valid[i]) begin
        chk($sformatf("busy%0d", i), busy[i], m_busy[i]);
        chk($sformatf("plwc%0d", i), plwc[i], m_plwc[i]);
        chk($sformatf("tc%0d", i), tc[i], m_tc[i]);
        chk($sformatf("data%0d", i), data[i], m_data[i]);
        chk($sformatf("wci%0d", i), wci[i], 1'b0);
        chk($sformatf("enw%0d", i), enw[i], dack[i]);
        chk($sformatf("incw%0d", i), incw[i], dack[i] & m_dir[i]);
        chk($sformatf("decw%0d", i), decw[i], dack[i] & ~m_dir[i]);
        if (dack[i] === 1'b1)
          chk($sformatf("dack_legal%0d", i),
              p_dreq[i] && p_busy[i] && !p_dack[i] && !p_plwc[i] && !p_tc[i], 1'b1);
        if (tc[i] === 1'b1)
          chk($sformatf("end_count%0d", i), wc[i], m_dir[i] ? 8'h00 : 8'hFF);
      end
      p_dack[i] = dack[i];
      p_dreq[i] = dreq[i];
      p_plwc[i] = plwc[i];
      p_tc[i]   = tc[i];
      p_busy[i] = busy[i];
      if (resseq[i]) begin
        m_valid[i] = 1'b1;
        m_busy[i] = 1'b0; m_plwc[i] = 1'b0; m_tc[i] = 1'b0; m_dir[i] = 1'b0;
        m_data[i] = 8'h00; m_base[i] = 8'h00; m_words[i] = 0; m_dcnt[i] = 0;
      end else if (abort[i]) begin
        m_busy[i] = 1'b0; m_plwc[i] = 1'b0; m_tc[i] = 1'b0;
      end else if (!m_busy[i] && start[i]) begin
        m_busy[i] = 1'b1; m_plwc[i] = 1'b1; m_tc[i] = 1'b0;
        m_base[i] = count[i]; m_data[i] = count[i]; m_dir[i] = dir[i];
        m_words[i] = dir[i] ? 256 - int'(count[i]) : int'(count[i]) + 1;
        m_dcnt[i] = 0;
      end else begin
        n_tc = (dack[i] === 1'b1) && (m_dcnt[i] + 1 == m_words[i]);
        if (dack[i] === 1'b1) m_dcnt[i]++;
        n_plwc = m_tc[i] && AUTO[i];
        if (n_plwc) begin
          m_dcnt[i] = 0;
          m_data[i] = m_base[i];
        end
        if (m_tc[i] && !AUTO[i]) m_busy[i] = 1'b0;
        m_plwc[i] = n_plwc;
        m_tc[i] = n_tc;
      end
    end
  end

  // start in cycle 0 with dreq held high; w words -> dacks on odd cycles 3..2w+1, tc at 2w+2
  task automatic run_lit(input int i, input logic [7:0] cnt, input logic d, input int w,
                         input string nm);
    tick;
    count[i] = cnt; dir[i] = d; dreq[i] = 1'b1; start[i] = 1'b1;
    for (int c = 1; c <= 2 * w + 3; c++) begin
      tick;
      start[i] = 1'b0;
      @(negedge clk);
      chk({nm, "_plwc"}, plwc[i], c == 1);
      chk({nm, "_dack"}, dack[i], (c >= 3) && (c <= 2 * w + 1) && (c % 2 == 1));
      chk({nm, "_tc"}, tc[i], c == 2 * w + 2);
      chk({nm, "_busy"}, busy[i], c <= 2 * w + 2);
      if (dack[i] === 1'b1) begin
        chk({nm, "_incw"}, incw[i], d);
        chk({nm, "_decw"}, decw[i], !d);
      end
    end
    chk({nm, "_counter"}, wc[i], d ? 8'h00 : 8'hFF);
    tick;
    dreq[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    resseq = 2'b11; start = 2'b00; abort = 2'b00; dreq = 2'b00; dir = 2'b00;
    count[0] = 8'h00; count[1] = 8'h00;
    tick;
    tick;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      chk($sformatf("rst_data%0d", i), data[i], 8'h00);
      chk($sformatf("rst_state%0d", i), dbg[i], 3'd0);
      chk($sformatf("rst_strobes%0d", i), {dack[i], plwc[i], enw[i], tc[i]}, 4'b0000);
    end
    tick;
    resseq = 2'b00;

    run_lit(0, 8'd2, 1'b0, 3, "r033");
    run_lit(0, 8'd0, 1'b0, 1, "r034");
    run_lit(0, 8'hFE, 1'b1, 2, "r035");

    // abort and start together in IDLE: nothing starts
    tick;
    count[0] = 8'd9; start[0] = 1'b1; abort[0] = 1'b1;
    tick;
    start[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy[0], 1'b0);
    chk("abort_start_plwc", plwc[0], 1'b0);

    // abort in WAIT after the first word
    tick;
    count[0] = 8'd5; dir[0] = 1'b0; dreq[0] = 1'b1; start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    tick;
    tick;
    @(negedge clk);
    chk("r036_first_dack", dack[0], 1'b1);
    tick;
    abort[0] = 1'b1;
    @(negedge clk);
    chk("r036_wait_busy", busy[0], 1'b1);
    chk("r036_wait_dack", dack[0], 1'b0);
    tick;
    abort[0] = 1'b0;
    @(negedge clk);
    chk("r036_idle_busy", busy[0], 1'b0);
    chk("r036_idle_dack", dack[0], 1'b0);
    chk("r036_counter", wc[0], 8'h04);
    tick;
    tick;
    @(negedge clk);
    chk("r036_no_tc", tc[0], 1'b0);
    chk("r036_counter_hold", wc[0], 8'h04);
    tick;
    dreq[0] = 1'b0;
    run_lit(0, 8'd1, 1'b0, 2, "r036_restart");

    // up block with gapped dreq and an ignored start mid-block
    tick;
    count[0] = 8'hF0; dir[0] = 1'b1; start[0] = 1'b1; dreq[0] = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      tick;
      dreq[0] = (c % 3 != 0);
      start[0] = (c == 10);
      count[0] = (c == 10) ? 8'd7 : 8'hF0;
      @(negedge clk);
      if (tc[0] === 1'b1) seen = 1'b1;
    end
    chk("pat_tc_seen", seen, 1'b1);
    chk("pat_counter", wc[0], 8'h00);
    tick;
    start[0] = 1'b0; dreq[0] = 1'b0; dir[0] = 1'b0;

    // AUTOINIT reload: two blocks of 2 words back to back, busy never drops
    tick;
    count[1] = 8'd1; dir[1] = 1'b0; dreq[1] = 1'b1; start[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      start[1] = 1'b0;
      @(negedge clk);
      chk("r037_busy", busy[1], 1'b1);
      chk("r037_plwc", plwc[1], (c == 1) || (c == 7));
      chk("r037_dack", dack[1], (c == 3) || (c == 5) || (c == 9) || (c == 11));
      chk("r037_tc", tc[1], (c == 6) || (c == 12));
      if (plwc[1] === 1'b1) chk("r037_data", data[1], 8'd1);
    end
    tick;
    abort[1] = 1'b1;
    tick;
    abort[1] = 1'b0; dreq[1] = 1'b0;
    @(negedge clk);
    chk("r037_abort_busy", busy[1], 1'b0);

    // reset during XFER, with start asserted alongside
    tick;
    count[0] = 8'd3; dir[0] = 1'b0; dreq[0] = 1'b1; start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    tick;
    tick;
    resseq[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    chk("r038_xfer_dack", dack[0], 1'b1);
    tick;
    resseq[0] = 1'b0; start[0] = 1'b0;
    @(negedge clk);
    chk("r038_outputs", {dack[0], plwc[0], enw[0], incw[0], decw[0], busy[0], tc[0]}, 7'd0);
    chk("r038_data", data[0], 8'h00);
    chk("r038_state", dbg[0], 3'd0);
    tick;
    dreq[0] = 1'b0;
    @(negedge clk);
    chk("r038_still_idle", busy[0], 1'b0);

    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
